pic_jump_ctrl: RTL and testbench
================================

Name: pic_jump_ctrl

Overview:
Frame-synchronous motion controller for the bouncing ROM picture. It consumes pixel coordinates from the VGA timing generator and owns the picture origin (pic_x, pic_y) and the per-axis direction. It moves the origin once per N frames, reflects off the active-area walls, and sequences the picture-ROM read enable and address for the pixel datapath.

Parameters:
H_VALID, 640, active pixels per line
V_VALID, 480, active lines per frame
H_PIC, 100, picture width
V_PIC, 100, picture height
PIC_SIZE, 10000, ROM depth (H_PIC*V_PIC)
ADDR_W, 14, ROM address width
STEP, 1, pixels moved per update, per axis
FRAME_DIV, 1, frames per position update (>=1)

Ports:
sys_clk  in  1  pixel clock; all logic on rising edge
sys_rst_n  in  1  synchronous active-low reset
pix_x  in  10  current pixel column; 10'h3FF outside active area
pix_y  in  10  current pixel row; 10'h3FF outside active area
pause  in  1  freeze motion; sampled at frame end only
pic_x  out  10  picture origin column
pic_y  out  10  picture origin row
x_dir  out  1  0 = +x (right), 1 = -x (left)
y_dir  out  1  0 = +y (down), 1 = -y (up)
rom_rd_en  out  1  ROM read strobe
rom_addr  out  ADDR_W  ROM read address
pic_valid  out  1  rom_rd_en delayed 1 cycle; aligns with ROM q
bounce  out  1  1-cycle pulse on any wall reflection

Behaviour:
- Clock is sys_clk. Reset is synchronous, active-low, on sys_rst_n. Reset sets every output and internal register to 0: pic_x, pic_y, x_dir, y_dir, rom_rd_en, rom_addr, pic_valid, bounce, frame_cnt, addr_cnt.
- frame_end is a combinational pulse: pix_x==H_VALID-1 and pix_y==V_VALID-1.
- frame_cnt counts 0..FRAME_DIV-1 and advances only on frame_end with pause==0. A move happens on frame_end when pause==0 and frame_cnt==FRAME_DIV-1. The new origin is registered on the next edge and is visible from the first pixel of the next frame. There is no mid-frame tearing.
- X axis, dir 0: if pic_x+STEP >= H_VALID-H_PIC, then pic_x <= H_VALID-H_PIC, x_dir <= 1, and bounce is raised. Otherwise pic_x += STEP.
- X axis, dir 1: if pic_x <= STEP, then pic_x <= 0, x_dir <= 0, and bounce is raised. Otherwise pic_x -= STEP.
- Y axis uses the same rules with V_VALID, V_PIC and y_dir.
- Compare at 11 bits so that pic_x+STEP cannot overflow.
- A simultaneous x and y reflection (corner) gives a single bounce pulse.
- in_win = pix_x in [pic_x, pic_x+H_PIC-1] and pix_y in [pic_y, pic_y+V_PIC-1]. Invalid coordinates (10'h3FF) are never in window.
- Registered on each edge:
  - rom_rd_en <= in_win.
  - When in_win: rom_addr <= addr_cnt, then addr_cnt increments and wraps from PIC_SIZE-1 to 0.
- addr_cnt clears to 0 on frame_end, which takes priority over increment.
- Latency is 1 cycle from pix coordinate to rom_rd_en/rom_addr, and 1 further cycle to pic_valid.
- rom_addr holds its last value while rom_rd_en==0.
- pause affects motion only. ROM addressing continues with the frozen origin.

Optional Feature:
- Macro: PIC_JUMP_BOUNCE_CNT_EN.
- Defined: adds output bounce_cnt[15:0]. It increments by 1 per bounce pulse, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package pic_jump_pkg holds:
  - DIR_POS=1'b0 and DIR_NEG=1'b1.
  - Default active-area and picture-size constants.
  - Coordinate width 10.
- Natural sub-module: pic_axis_bounce. It holds one axis position register, the direction flip-flop and the reflection logic. Parameters are LIMIT=VALID-PIC and STEP; inputs are move and the sync reset; outputs are pos, dir and hit.
  - Instantiate it twice (x, y). bounce = hit_x | hit_y, registered.
- Address generation and frame_cnt stay in the top level.

Test Plan:
- Bench settings for all scenarios: H_VALID=60, V_VALID=50, H_PIC=10, V_PIC=10, PIC_SIZE=100, STEP=1, FRAME_DIV=1.
- Reset -> all outputs 0. After the first frame_end -> pic_x=1, pic_y=1, dirs 0, bounce 0.
- Right wall: pic_x=49, x_dir=0 at frame_end -> pic_x=50, x_dir=1, one-cycle bounce. Next frame -> pic_x=49.
- Left/top corner: pic_x=1, pic_y=1, both dirs 1 -> pic_x=0, pic_y=0, both dirs 0, exactly one bounce pulse.
- ROM sequencing, origin (0,0): rom_rd_en high 10 cycles per line for lines 0..9, addresses 0..99 contiguous, 0 again in the next frame. pic_valid lags rom_rd_en by exactly 1 cycle.
- Motion gating: FRAME_DIV=3 -> origin changes every 3rd frame_end. pause=1 at frame_end -> pic_x, pic_y and frame_cnt unchanged, ROM reads still occur.
- Reset mid-window: sys_rst_n low for one edge during rom_rd_en=1 -> next cycle all outputs 0. After release, motion restarts from (0,0).

Source files
------------

// File: rtl/pic_jump_pkg.sv
// Shared constants and types for the bouncing-picture motion controller.
// The bounce counter output is enabled by defining PIC_JUMP_BOUNCE_CNT_EN.
package pic_jump_pkg;

  localparam int COORD_W = 10;
  localparam int EXT_W   = COORD_W + 1;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;
  localparam int H_PIC_DEF   = 100;
  localparam int V_PIC_DEF   = 100;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t PIX_INVALID = 10'h3FF;

endpackage

// File: rtl/pic_axis_bounce.sv
// One motion axis: origin register, direction flop and wall reflection.
// hit is combinational and qualifies the move that reflects.
module pic_axis_bounce
  import pic_jump_pkg::*;
#(
  parameter int LIMIT = H_VALID_DEF - H_PIC_DEF,
  parameter int STEP  = 1
) (
  input  logic   sys_clk,
  input  logic   sys_rst_n,
  input  logic   move,
  output coord_t pos,
  output logic   dir,
  output logic   hit
);

  localparam logic [EXT_W-1:0] LIMIT_W = EXT_W'(LIMIT);
  localparam logic [EXT_W-1:0] STEP_W  = EXT_W'(STEP);

  coord_t           r_pos;
  coord_t           w_pos_next;
  coord_t           w_pos_dec;
  logic             r_dir;
  logic             w_dir_next;
  logic             w_hit;
  logic [EXT_W-1:0] w_pos_ext;
  logic [EXT_W-1:0] w_pos_inc;

  // The extra bit keeps pos+STEP from wrapping before the wall compare.
  assign w_pos_ext = {1'b0, r_pos};
  assign w_pos_inc = w_pos_ext + STEP_W;
  assign w_pos_dec = r_pos - COORD_W'(STEP);

  always_comb begin
    w_pos_next = r_pos;
    w_dir_next = r_dir;
    w_hit      = 1'b0;
    if (move) begin
      if (r_dir == DIR_POS) begin
        if (w_pos_inc >= LIMIT_W) begin
          w_pos_next = LIMIT_W[COORD_W-1:0];
          w_dir_next = DIR_NEG;
          w_hit      = 1'b1;
        end else begin
          w_pos_next = w_pos_inc[COORD_W-1:0];
        end
      end else begin
        if (w_pos_ext <= STEP_W) begin
          w_pos_next = '0;
          w_dir_next = DIR_POS;
          w_hit      = 1'b1;
        end else begin
          w_pos_next = w_pos_dec;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_pos <= '0;
      r_dir <= DIR_POS;
    end else begin
      r_pos <= w_pos_next;
      r_dir <= w_dir_next;
    end
  end

  assign pos = r_pos;
  assign dir = r_dir;
  assign hit = w_hit;

endmodule

// File: rtl/pic_jump_ctrl.sv
// Frame-synchronous bouncing-picture controller: origin motion plus ROM read sequencing.
// Optional bounce_cnt output when PIC_JUMP_BOUNCE_CNT_EN is defined.
module pic_jump_ctrl
  import pic_jump_pkg::*;
#(
  parameter int H_VALID   = H_VALID_DEF,
  parameter int V_VALID   = V_VALID_DEF,
  parameter int H_PIC     = H_PIC_DEF,
  parameter int V_PIC     = V_PIC_DEF,
  parameter int PIC_SIZE  = H_PIC_DEF * V_PIC_DEF,
  parameter int ADDR_W    = 14,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               pause,
  output logic [COORD_W-1:0] pic_x,
  output logic [COORD_W-1:0] pic_y,
  output logic               x_dir,
  output logic               y_dir,
  output logic               rom_rd_en,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               pic_valid,
  output logic               bounce
`ifdef PIC_JUMP_BOUNCE_CNT_EN
  ,
  output logic [15:0]        bounce_cnt
`endif
);

  localparam int               FC_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(FRAME_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIC_SIZE - 1);
  localparam coord_t           H_LAST    = COORD_W'(H_VALID - 1);
  localparam coord_t           V_LAST    = COORD_W'(V_VALID - 1);

  logic [FC_W-1:0]   r_frame_cnt;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_rom_rd_en;
  logic              r_pic_valid;
  logic              r_bounce;

  logic              w_frame_end;
  logic              w_move;
  logic              w_bounce_next;
  logic              w_in_x;
  logic              w_in_y;
  logic              w_in_win;
  logic [EXT_W-1:0]  w_x_hi;
  logic [EXT_W-1:0]  w_y_hi;
  coord_t            w_pos [2];
  logic [1:0]        w_dir;
  logic [1:0]        w_hit;

  assign w_frame_end = (pix_x == H_LAST) && (pix_y == V_LAST);
  assign w_move      = w_frame_end && !pause && (r_frame_cnt == FC_LAST);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_end && !pause) begin
      r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + FC_W'(1);
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_axis
    pic_axis_bounce #(
      .LIMIT ((gi == 0) ? (H_VALID - H_PIC) : (V_VALID - V_PIC)),
      .STEP  (STEP)
    ) u_axis (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .move      (w_move),
      .pos       (w_pos[gi]),
      .dir       (w_dir[gi]),
      .hit       (w_hit[gi])
    );
  end

  assign w_bounce_next = |w_hit;

  // Window bounds widened so pic+size-1 never wraps near the far wall.
  assign w_x_hi   = {1'b0, w_pos[0]} + EXT_W'(H_PIC - 1);
  assign w_y_hi   = {1'b0, w_pos[1]} + EXT_W'(V_PIC - 1);
  assign w_in_x   = (pix_x != PIX_INVALID) && (pix_x >= w_pos[0]) && ({1'b0, pix_x} <= w_x_hi);
  assign w_in_y   = (pix_y != PIX_INVALID) && (pix_y >= w_pos[1]) && ({1'b0, pix_y} <= w_y_hi);
  assign w_in_win = w_in_x && w_in_y;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rom_rd_en <= 1'b0;
      r_rom_addr  <= '0;
      r_addr_cnt  <= '0;
      r_pic_valid <= 1'b0;
      r_bounce    <= 1'b0;
    end else begin
      r_rom_rd_en <= w_in_win;
      r_pic_valid <= r_rom_rd_en;
      r_bounce    <= w_bounce_next;
      if (w_in_win) begin
        r_rom_addr <= r_addr_cnt;
      end
      // Frame restart wins even if the last active pixel is inside the picture.
      if (w_frame_end) begin
        r_addr_cnt <= '0;
      end else if (w_in_win) begin
        r_addr_cnt <= (r_addr_cnt == ADDR_LAST) ? '0 : r_addr_cnt + ADDR_W'(1);
      end
    end
  end

`ifdef PIC_JUMP_BOUNCE_CNT_EN
  logic [15:0] r_bounce_cnt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_bounce_cnt <= '0;
    end else if (w_bounce_next && (r_bounce_cnt != 16'hFFFF)) begin
      r_bounce_cnt <= r_bounce_cnt + 16'd1;
    end
  end

  assign bounce_cnt = r_bounce_cnt;
`endif

  assign pic_x     = w_pos[0];
  assign pic_y     = w_pos[1];
  assign x_dir     = w_dir[0];
  assign y_dir     = w_dir[1];
  assign rom_rd_en = r_rom_rd_en;
  assign rom_addr  = r_rom_addr;
  assign pic_valid = r_pic_valid;
  assign bounce    = r_bounce;

endmodule

// File: tb/tb_pic_jump_ctrl.sv
// Scoreboard bench for pic_jump_ctrl: two instances (FRAME_DIV 1 and 3) share stimulus,
// a behavioural model queues the expected outputs, and a monitor compares each cycle.
module tb_pic_jump_ctrl;

  localparam int HV = 60;
  localparam int VV = 50;
  localparam int HP = 10;
  localparam int VP = 10;
  localparam int PS = 100;
  localparam int AW = 14;
  localparam int ST = 1;
  localparam int INV = 1023;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [9:0] px = 10'h3FF;
  logic [9:0] py = 10'h3FF;
  logic       pse = 1'b0;

  logic [9:0]    o_pic_x [2];
  logic [9:0]    o_pic_y [2];
  logic          o_x_dir [2];
  logic          o_y_dir [2];
  logic          o_rd_en [2];
  logic [AW-1:0] o_addr  [2];
  logic          o_valid [2];
  logic          o_bounce[2];
`ifdef PIC_JUMP_BOUNCE_CNT_EN
  logic [15:0]   o_bcnt  [2];
`endif

  always #5 clk = ~clk;

  pic_jump_ctrl #(
    .H_VALID(HV), .V_VALID(VV), .H_PIC(HP), .V_PIC(VP), .PIC_SIZE(PS),
    .ADDR_W(AW), .STEP(ST), .FRAME_DIV(1)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rstn), .pix_x(px), .pix_y(py), .pause(pse),
    .pic_x(o_pic_x[0]), .pic_y(o_pic_y[0]), .x_dir(o_x_dir[0]), .y_dir(o_y_dir[0]),
    .rom_rd_en(o_rd_en[0]), .rom_addr(o_addr[0]), .pic_valid(o_valid[0]), .bounce(o_bounce[0])
`ifdef PIC_JUMP_BOUNCE_CNT_EN
    , .bounce_cnt(o_bcnt[0])
`endif
  );

  pic_jump_ctrl #(
    .H_VALID(HV), .V_VALID(VV), .H_PIC(HP), .V_PIC(VP), .PIC_SIZE(PS),
    .ADDR_W(AW), .STEP(ST), .FRAME_DIV(3)
  ) dut3 (
    .sys_clk(clk), .sys_rst_n(rstn), .pix_x(px), .pix_y(py), .pause(pse),
    .pic_x(o_pic_x[1]), .pic_y(o_pic_y[1]), .x_dir(o_x_dir[1]), .y_dir(o_y_dir[1]),
    .rom_rd_en(o_rd_en[1]), .rom_addr(o_addr[1]), .pic_valid(o_valid[1]), .bounce(o_bounce[1])
`ifdef PIC_JUMP_BOUNCE_CNT_EN
    , .bounce_cnt(o_bcnt[1])
`endif
  );

  typedef struct {
    int px, py, dx, dy, fcnt, acnt, rom_en, rom_addr, valid, bounce, bcnt;
  } st_t;

  typedef struct {
    st_t e0;
    st_t e1;
  } exp_t;

  exp_t q[$];
  st_t  ms[2];
  int   fdiv[2] = '{1, 3};
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Moving toward a wall: step, and if the wall is reached or passed, stop on it and turn around.
  function automatic void axis_move(input int pos, input int dir, input int limit,
                                    output int npos, output int ndir, output int hit);
    hit  = 0;
    ndir = dir;
    if (dir == 0) begin
      npos = pos + ST;
      if (npos >= limit) begin npos = limit; ndir = 1; hit = 1; end
    end else begin
      npos = pos - ST;
      if (npos <= 0) begin npos = 0; ndir = 0; hit = 1; end
    end
  endfunction

  function automatic st_t mstep(input st_t s, input int x, input int y, input bit p,
                                input bit rn, input int fd);
    st_t n;
    st_t z;
    bit  fe, win;
    int  hx, hy;
    z = '{default: 0};
    if (!rn) return z;
    n   = s;
    fe  = (x == HV - 1) && (y == VV - 1);
    win = (x != INV) && (y != INV) && (x >= s.px) && (x <= s.px + HP - 1)
          && (y >= s.py) && (y <= s.py + VP - 1);
    n.rom_en = win;
    n.valid  = s.rom_en;
    if (win) n.rom_addr = s.acnt;
    if (fe)       n.acnt = 0;
    else if (win) n.acnt = (s.acnt + 1) % PS;
    n.bounce = 0;
    if (fe && !p) begin
      if (s.fcnt + 1 == fd) begin
        n.fcnt = 0;
        axis_move(s.px, s.dx, HV - HP, n.px, n.dx, hx);
        axis_move(s.py, s.dy, VV - VP, n.py, n.dy, hy);
        n.bounce = (hx | hy);
      end else begin
        n.fcnt = s.fcnt + 1;
      end
    end
    if (n.bounce != 0 && n.bcnt < 65535) n.bcnt = n.bcnt + 1;
    return n;
  endfunction

  task automatic drive(input int x, input int y, input bit p, input bit rn);
    exp_t e;
    @(negedge clk);
    px   = 10'(x);
    py   = 10'(y);
    pse  = p;
    rstn = rn;
    for (int k = 0; k < 2; k++) begin
      ms[k] = mstep(ms[k], x, y, p, rn, fdiv[k]);
      if (ms[k].bounce != 0)
        $display("bounce dut%0d -> origin (%0d,%0d) dirs (%0d,%0d)",
                 k, ms[k].px, ms[k].py, ms[k].dx, ms[k].dy);
    end
    e.e0 = ms[0];
    e.e1 = ms[1];
    q.push_back(e);
  endtask

  task automatic raster_frame(input bit p);
    for (int v = 0; v < VV + 2; v++)
      for (int h = 0; h < HV + 2; h++)
        drive((h < HV && v < VV) ? h : INV, (h < HV && v < VV) ? v : INV, p, 1'b1);
  endtask

  task automatic cmp_dut(input int k, input st_t s);
    chk("pic_x",     k, 32'(o_pic_x[k]),  s.px);
    chk("pic_y",     k, 32'(o_pic_y[k]),  s.py);
    chk("x_dir",     k, 32'(o_x_dir[k]),  s.dx);
    chk("y_dir",     k, 32'(o_y_dir[k]),  s.dy);
    chk("bounce",    k, 32'(o_bounce[k]), s.bounce);
    chk("rom_rd_en", k, 32'(o_rd_en[k]),  s.rom_en);
    chk("rom_addr",  k, 32'(o_addr[k]),   s.rom_addr);
    chk("pic_valid", k, 32'(o_valid[k]),  s.valid);
`ifdef PIC_JUMP_BOUNCE_CNT_EN
    chk("bounce_cnt", k, 32'(o_bcnt[k]),  s.bcnt);
`endif
  endtask

  // Monitor: every clock the DUT presents a new output set; match it to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp_dut(0, e.e0);
        cmp_dut(1, e.e1);
      end
    end
  end

  initial begin
    int r, x, y, w;
    bit p, rn;
    ms[0] = '{default: 0};
    ms[1] = '{default: 0};

    repeat (3) drive(INV, INV, 1'b0, 1'b0);
    $display("phase raster: origin starts at (0,0)");
    repeat (3) raster_frame(1'b0);

    $display("phase reset inside window");
    drive(5, 5, 1'b0, 1'b1);
    drive(6, 5, 1'b0, 1'b0);
    repeat (3) drive(INV, INV, 1'b0, 1'b1);

    $display("phase wall/corner burst");
    repeat (420) drive(HV - 1, VV - 1, 1'b0, 1'b1);

    $display("phase pause at frame end");
    repeat (20) drive(HV - 1, VV - 1, 1'b1, 1'b1);
    raster_frame(1'b1);

    $display("phase random");
    repeat (20000) begin
      r = $urandom_range(99);
      if (r < 10) begin
        x = HV - 1; y = VV - 1;
      end else if (r < 15) begin
        x = INV; y = $urandom_range(VV - 1);
      end else if (r < 18) begin
        x = $urandom_range(HV - 1); y = INV;
      end else begin
        x = $urandom_range(HV + 5); y = $urandom_range(VV + 5);
      end
      p  = ($urandom_range(3) == 0);
      rn = ($urandom_range(299) != 0);
      drive(x, y, p, rn);
    end

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #2;
    chk("drain", 0, 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
